matrix_result_scanner: RTL and testbench

//   Downstream display stage of the matrix-multiply datapath. On a load pulse it captures the
//   256-bit result word (packed 5x5 matrix of 8-bit elements, row-major, element (r,c) at bits
//   [(r*5+c)*8 +: 8]). It then steps through the active size x size sub-matrix one element per

---
 rtl/matrix_result_scanner.sv | 142 ++++++++++++++
 tb/tb_matrix_result_scanner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/matrix_result_scanner.sv
// matrix_result_scanner
//   Display stage for the matrix-multiply datapath. A load pulse captures a packed
//   MAX_DIM x MAX_DIM result word (row-major, ELEM_W bits per element) together with
//   the active dimension. The block then walks the dim x dim sub-matrix one element
//   per display tick, shows the element on the LEDs and wraps forever.
//
//   Optional build macro: SCAN_GAP_EN -- inserts a one-tick blank GAP state after the
//   last element of every pass; pass_done then fires on GAP entry.
//
// Ports
//   clk        system clock (posedge)
//   rst        asynchronous active-low reset
//   load       1-cycle pulse: capture matrix_in/size and restart the scan
//   size       matrix dimension, sampled on load (clamped to 1..MAX_DIM)
//   matrix_in  packed result word
//   hold       freeze prescaler, indices and leds
//   leds       displayed element (registered)
//   row, col   index of the element currently being scanned
//   busy       high once loaded (SHOW or GAP)
//   pass_done  1-cycle pulse at the end of each pass
module matrix_result_scanner #(
  parameter int DATA_W   = 256,
  parameter int ELEM_W   = 8,
  parameter int MAX_DIM  = 5,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [2:0]        size,
  input  logic [DATA_W-1:0] matrix_in,
  input  logic              hold,
  output logic [ELEM_W-1:0] leds,
  output logic [2:0]        row,
  output logic [2:0]        col,
  output logic              busy,
  output logic              pass_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef SCAN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  state_t            state, state_n;
  logic [DATA_W-1:0] word, word_n;
  logic [2:0]        dim, dim_n;
  logic [2:0]        row_n, col_n;
  logic [PW-1:0]     presc, presc_n;
  logic [ELEM_W-1:0] leds_n;
  logic              pass_n;
  logic              tick;
  logic [4:0]        idx;
  logic [ELEM_W-1:0] elem;

  function automatic logic [2:0] clamp_dim(input logic [2:0] s);
    if (s <= 3'd1)              return 3'd1;
    else if (s > 3'(MAX_DIM))   return 3'(MAX_DIM);
    else                        return s;
  endfunction

  // 5-bit index is enough: largest element index is MAX_DIM*MAX_DIM-1 = 24.
  assign idx  = 5'(row) * 5'(MAX_DIM) + 5'(col);
  assign elem = word[ELEM_W*idx +: ELEM_W];
  assign tick = (presc == PW'(TICK_DIV-1));
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    word_n  = word;
    dim_n   = dim;
    row_n   = row;
    col_n   = col;
    presc_n = presc;
    leds_n  = leds;
    pass_n  = 1'b0;
    if (load) begin
      // load wins over hold and over a coinciding tick; aborted pass gives no pass_done
      state_n = SHOW;
      word_n  = matrix_in;
      dim_n   = clamp_dim(size);
      row_n   = '0;
      col_n   = '0;
      presc_n = '0;
    end else if (state != IDLE && !hold) begin
      // leds follows the index registers one cycle later
      leds_n  = elem;
      presc_n = tick ? '0 : presc + PW'(1);
      case (state)
        SHOW: if (tick) begin
          if (col == dim - 3'd1) begin
            col_n = '0;
            if (row == dim - 3'd1) begin
              row_n  = '0;
              pass_n = 1'b1;
`ifdef SCAN_GAP_EN
              state_n = GAP;
`endif
            end else begin
              row_n = row + 3'd1;
            end
          end else begin
            col_n = col + 3'd1;
          end
        end
`ifdef SCAN_GAP_EN
        GAP: begin
          leds_n = '0;
          if (tick) state_n = SHOW;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      word      <= '0;
      dim       <= 3'd1;
      row       <= '0;
      col       <= '0;
      presc     <= '0;
      leds      <= '0;
      pass_done <= 1'b0;
    end else begin
      state     <= state_n;
      word      <= word_n;
      dim       <= dim_n;
      row       <= row_n;
      col       <= col_n;
      presc     <= presc_n;
      leds      <= leds_n;
      pass_done <= pass_n;
    end
  end

endmodule

// File: tb/tb_matrix_result_scanner.sv
module tb_matrix_result_scanner;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [2:0]   size;
  logic [255:0] matrix_in;
  logic         hold;
  logic [7:0]   leds;
  logic [2:0]   row, col;
  logic         busy, pass_done;

  int n_chk = 0;
  int n_fail = 0;

  matrix_result_scanner #(.DATA_W(256), .ELEM_W(8), .MAX_DIM(5), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .load(load), .size(size), .matrix_in(matrix_in),
    .hold(hold), .leds(leds), .row(row), .col(col), .busy(busy), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // advance n posedges, land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_word(input logic [7:0] base);
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  // Pulse load; returns just after the load edge.
  task automatic do_load(input logic [255:0] w, input logic [2:0] s);
    matrix_in = w;
    size = s;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // Expected trace right after a load edge: element e is displayed on edges
  // 4e+1..4e+4, indices move on edges 4e, pass_done on every 4*d*d-th edge.
  task automatic scan_check(input string tag, input logic [7:0] base, input int d, input int ncyc);
    int n, el, ei;
    n = d * d;
    for (int c = 1; c <= ncyc; c++) begin
      step(1);
      el = ((c - 1) / TD) % n;
      ei = (c / TD) % n;
      chk({tag, "_leds"}, leds, base + 8'((el / d) * 5 + el % d));
      chk({tag, "_row"},  row, ei / d);
      chk({tag, "_col"},  col, ei % d);
      chk({tag, "_pass"}, pass_done, (c % (TD * n)) == 0);
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; size = 3'd0; matrix_in = '0; hold = 1'b0;
    #1;
    chk("rst_leds", leds, 0);
    chk("rst_row",  row, 0);
    chk("rst_col",  col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass_done, 0);
    step(2);
    rst = 1'b1;
    step(6);
    chk("idle_leds", leds, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pass", pass_done, 0);

`ifndef SCAN_GAP_EN
    // size 2: 01,02,06,07 then repeat
    do_load(mk_word(8'h01), 3'd2);
    chk("ld2_busy", busy, 1);
    chk("ld2_row", row, 0);
    chk("ld2_col", col, 0);
    scan_check("s2", 8'h01, 2, 32);

    // size 7 clamps to 5: 01..19
    do_load(mk_word(8'h01), 3'd7);
    scan_check("s7", 8'h01, 5, 2 * 100);

    // hold mid-element: element (0,1) with prescaler at 2
    do_load(mk_word(8'h01), 3'd3);
    step(6);
    chk("pre_hold_leds", leds, 8'h02);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_leds", leds, 8'h02);
      chk("hold_row",  row, 0);
      chk("hold_col",  col, 1);
      chk("hold_pass", pass_done, 0);
    end
    hold = 1'b0;
    step(1);
    chk("rel1_col", col, 1);
    step(1);
    chk("rel2_col", col, 2);
    chk("rel2_leds", leds, 8'h02);
    step(1);
    chk("rel3_leds", leds, 8'h03);

    // reload at (1,1) of a size-3 pass
    do_load(mk_word(8'h01), 3'd3);
    step(17);
    chk("pre_rl_row", row, 1);
    chk("pre_rl_col", col, 1);
    chk("pre_rl_leds", leds, 8'h07);
    do_load(mk_word(8'h80), 3'd2);
    chk("rl_row", row, 0);
    chk("rl_col", col, 0);
    chk("rl_pass", pass_done, 0);
    chk("rl_leds_hold", leds, 8'h07);
    scan_check("rl", 8'h80, 2, 16);

    // async reset mid-pass, captured word lost
    step(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_leds", leds, 0);
    chk("arst_busy", busy, 0);
    chk("arst_row", row, 0);
    chk("arst_col", col, 0);
    step(1);
    rst = 1'b1;
    step(8);
    chk("post_rst_leds", leds, 0);
    chk("post_rst_busy", busy, 0);

    // size 0 -> dim 1: leds stays (0,0), pass_done every tick
    do_load(mk_word(8'h01), 3'd0);
    scan_check("s0", 8'h01, 1, 16);
`else
    // GAP build, size 1: 01 for a tick, 00 for a tick, pass_done on GAP entry
    do_load(mk_word(8'h01), 3'd1);
    for (int c = 1; c <= 16; c++) begin
      step(1);
      chk("gap_leds", leds, (((c - 1) / TD) % 2 == 0) ? 8'h01 : 8'h00);
      chk("gap_pass", pass_done, (c % (2 * TD)) == TD);
      chk("gap_row", row, 0);
      chk("gap_col", col, 0);
    end
    step(5);
    #2 rst = 1'b0;
    #1;
    chk("gap_arst_leds", leds, 0);
    chk("gap_arst_busy", busy, 0);
    chk("gap_arst_pass", pass_done, 0);
    step(1);
    rst = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
